divider_multicycle: RTL and testbench

//  Iterative multi-cycle integer divider for the execute stage (MIPS DIV/DIVU).
//  - Radix-2^BPC restoring division on magnitudes, then sign fix-up.
//  - Produces hi = remainder and lo = quotient.
//  - Valid/ready handshake on input and output, so the pipeline stalls on in_ready/out_valid.
//  - Replaces the vendor divider IP and supports flush on exceptions and branches.

---
 rtl/divider_multicycle_pkg.sv | 19 +
 rtl/divider_multicycle_div_step.sv | 24 ++
 rtl/divider_multicycle.sv | 114 +++++++++++
 tb/tb_divider_multicycle.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_multicycle_pkg.sv
// Shared types and constants for the multi-cycle integer divider.
package divider_multicycle_pkg;

   localparam int WORD_W  = 32;
   localparam int BPC_DEF = 1;

   typedef logic [WORD_W-1:0]   word_t;
   typedef logic [2*WORD_W-1:0] dword_t;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      FIX,
      DONE
   } div_state_t;

   localparam int DIV_CNT_W = $clog2(WORD_W/BPC_DEF + 1);

endpackage

// File: rtl/divider_multicycle_div_step.sv
// One restoring-division step: shift a dividend bit into the remainder and trial-subtract.
module divider_multicycle_div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic [WIDTH-1:0] divisor,
   input  logic             bit_in,
   output logic [WIDTH-1:0] rem_out,
   output logic             q_bit
);

   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] diff;

   // When the trial fits the divisor the true difference is below the divisor, so
   // the low WIDTH bits of the subtraction are exact.
   always_comb begin
      trial   = {rem_in, bit_in};
      diff    = trial[WIDTH-1:0] - divisor;
      q_bit   = (trial >= {1'b0, divisor});
      rem_out = q_bit ? diff : trial[WIDTH-1:0];
   end

endmodule

// File: rtl/divider_multicycle.sv
// Iterative radix-2^BPC restoring divider (DIV/DIVU) with valid/ready handshakes and flush.
module divider_multicycle
   import divider_multicycle_pkg::*;
#(
   parameter int WIDTH = WORD_W,
   parameter int BPC   = BPC_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             is_signed,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int N_STEPS = WIDTH / BPC;
   localparam int CNT_W   = $clog2(N_STEPS + 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(N_STEPS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

   div_state_t       state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] dvd, dvs, rem;
   logic             sign_q, sign_r;
   logic             accept;

   logic [WIDTH-1:0] rem_chain [BPC+1];
   logic [BPC-1:0]   q_grp;

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic en);
      logic signed [WIDTH-1:0] sx;
      sx = x;
      return (en && sx < 0) ? WIDTH'(-sx) : x;
   endfunction

   function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] x, input logic neg);
      logic signed [WIDTH-1:0] sx;
      sx = x;
      return neg ? WIDTH'(-sx) : x;
   endfunction

   assign accept = in_valid & in_ready & ~flush;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (accept) state_nxt = BUSY;
         BUSY:    if (cnt == CNT_LAST) state_nxt = FIX;
         FIX:     state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (flush) state_nxt = IDLE;
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (reset)               cnt <= '0;
      else if (accept)         cnt <= CNT_INIT;
      else if (state == BUSY)  cnt <= cnt - CNT_LAST;
   end

   // Quotient bits retire into the low end of the dividend register as it drains.
   assign rem_chain[0] = rem;
   for (genvar i = 0; i < BPC; i++) begin : g_step
      divider_multicycle_div_step #(.WIDTH(WIDTH)) u_step (
         .rem_in  (rem_chain[i]),
         .divisor (dvs),
         .bit_in  (dvd[WIDTH-1-i]),
         .rem_out (rem_chain[i+1]),
         .q_bit   (q_grp[BPC-1-i])
      );
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         dvd    <= magnitude(a, is_signed);
         dvs    <= magnitude(b, is_signed);
         rem    <= '0;
         sign_q <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
         sign_r <= is_signed & a[WIDTH-1];
      end else if (state == BUSY) begin
         dvd <= {dvd[WIDTH-BPC-1:0], q_grp};
         rem <= rem_chain[BPC];
      end
   end

   // Results survive a flush; only reset clears them.
   always_ff @(posedge clk) begin
      if (reset) begin
         hi <= '0;
         lo <= '0;
      end else if (state == FIX && !flush) begin
         lo <= apply_sign(dvd, sign_q);
         hi <= apply_sign(rem, sign_r);
      end
   end

endmodule

// File: tb/tb_divider_multicycle.sv
// Self-checking bench for divider_multicycle: directed corner cases plus randomized ops vs. a model.
module tb_divider_multicycle;

   localparam int W   = 32;
   localparam int BPC = 1;
   localparam int LAT = W / BPC + 1;
   localparam int TMO = 200;

   logic         clk = 1'b0;
   logic         reset, flush, in_valid, in_ready, is_signed, out_valid, out_ready;
   logic [W-1:0] a, b, hi, lo;

   int checks = 0;
   int errors = 0;

   divider_multicycle #(.WIDTH(W), .BPC(BPC)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .is_signed (is_signed),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .hi        (hi),
      .lo        (lo)
   );

   always #5 clk = ~clk;

   // Reference: plain integer arithmetic, C-style truncation, with the b==0 convention.
   function automatic void ref_div(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                                   output logic [W-1:0] q, output logic [W-1:0] r);
      longint sx, sy;
      if (y == 0) begin
         q = (s && x[W-1]) ? W'(1) : '1;
         r = x;
      end else if (s) begin
         sx = longint'($signed(x));
         sy = longint'($signed(y));
         q  = W'(sx / sy);
         r  = W'(sx % sy);
      end else begin
         q = x / y;
         r = x % y;
      end
   endfunction

   // Drives one op through both handshakes; called at #1 after a rising edge.
   task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                        output logic [W-1:0] q, output logic [W-1:0] r, output int lat,
                        output logic rdy);
      a = x; b = y; is_signed = s; in_valid = 1'b1;
      rdy = in_ready;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = $urandom; b = $urandom; is_signed = $urandom_range(0, 1);
      lat = 0;
      while (!out_valid && lat < TMO) begin
         @(posedge clk); #1;
         lat++;
      end
      q = lo; r = hi;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; is_signed = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || hi !== '0 || lo !== '0) begin
         errors++;
         $display("FAIL reset: in_ready=%b out_valid=%b hi=%h lo=%h, required 1 0 0 0",
                  in_ready, out_valid, hi, lo);
      end
   endtask

   task automatic test_directed();
      logic [W-1:0] va [8] = '{32'd7, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FFFF,
                               32'd5, 32'hFFFF_FFFB, 32'd100};
      logic [W-1:0] vb [8] = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h10,
                               32'd0, 32'd0, 32'd7};
      logic         vs [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [W-1:0] eq [8] = '{32'd3, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000,
                               32'h0FFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd14};
      logic [W-1:0] er [8] = '{32'd1, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hF, 32'd5,
                               32'hFFFF_FFFB, 32'd2};
      logic [W-1:0] q, r;
      int           lat;
      logic         rdy;
      for (int i = 0; i < 8; i++) begin
         do_op(va[i], vb[i], vs[i], q, r, lat, rdy);
         checks++;
         if (rdy !== 1'b1 || lat !== LAT) begin
            errors++;
            $display("FAIL directed_lat[%0d]: ready=%b latency=%0d, required 1 %0d", i, rdy, lat, LAT);
         end
         checks++;
         if (q !== eq[i] || r !== er[i]) begin
            errors++;
            $display("FAIL directed_res[%0d]: lo=%h hi=%h, required lo=%h hi=%h", i, q, r, eq[i], er[i]);
         end
      end
   endtask

   task automatic test_flush();
      logic [W-1:0] q, r;
      int           lat, seen;
      logic         rdy;
      // flush alongside in_valid in IDLE must not accept
      a = 32'd9; b = 32'd3; is_signed = 1'b0; in_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_idle: in_ready=%b, required 1", in_ready);
      end
      a = 32'd1000; b = 32'd3; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_busy: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
      end
      seen = 0;
      for (int i = 0; i < LAT + 5; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL flush_no_valid: out_valid cycles=%0d, required 0", seen);
      end
      do_op(32'd100, 32'd7, 1'b0, q, r, lat, rdy);
      checks++;
      if (rdy !== 1'b1 || lat !== LAT || q !== 32'd14 || r !== 32'd2) begin
         errors++;
         $display("FAIL flush_recover: ready=%b lat=%0d lo=%0d hi=%0d, required 1 %0d 14 2",
                  rdy, lat, q, r, LAT);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] q0, r0;
      int           lat;
      a = 32'd77; b = 32'd5; is_signed = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < TMO) begin
         @(posedge clk); #1;
         lat++;
      end
      q0 = lo; r0 = hi;
      checks++;
      if (lat !== LAT || q0 !== 32'd15 || r0 !== 32'd2) begin
         errors++;
         $display("FAIL hold_first: lat=%0d lo=%0d hi=%0d, required %0d 15 2", lat, q0, r0, LAT);
      end
      for (int i = 0; i < 5; i++) begin
         a = 32'd1000 + W'(i); b = 32'd3; in_valid = 1'b1;
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || lo !== q0 || hi !== r0) begin
            errors++;
            $display("FAIL hold[%0d]: out_valid=%b in_ready=%b lo=%h hi=%h, required 1 0 %h %h",
                     i, out_valid, in_ready, lo, hi, q0, r0);
         end
      end
      a = 32'd100; b = 32'd7; is_signed = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL handshake_idle: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < TMO) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (lat !== LAT || lo !== 32'd14 || hi !== 32'd2) begin
         errors++;
         $display("FAIL back_to_back: lat=%0d lo=%0d hi=%0d, required %0d 14 2", lat, lo, hi, LAT);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid_op();
      a = 32'd50; b = 32'd3; is_signed = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || hi !== '0 || lo !== '0) begin
         errors++;
         $display("FAIL reset_mid_op: in_ready=%b out_valid=%b hi=%h lo=%h, required 1 0 0 0",
                  in_ready, out_valid, hi, lo);
      end
   endtask

   task automatic test_random();
      logic [W-1:0] x, y, q, r, eq, er;
      logic         s, rdy;
      int           lat;
      for (int i = 0; i < 40; i++) begin
         x = $urandom;
         case ($urandom_range(0, 4))
            0:       y = $urandom;
            1:       y = W'($urandom_range(0, 15));
            2:       y = W'(0) - W'($urandom_range(1, 15));
            3:       y = (x >> $urandom_range(1, 20));
            default: y = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h8000_0000;
         endcase
         if ($urandom_range(0, 7) == 0) x = 32'h8000_0000;
         s = $urandom_range(0, 1);
         ref_div(x, y, s, eq, er);
         do_op(x, y, s, q, r, lat, rdy);
         checks++;
         if (rdy !== 1'b1 || lat !== LAT || q !== eq || r !== er) begin
            errors++;
            $display("FAIL random[%0d] %h/%h s=%b: ready=%b lat=%0d lo=%h hi=%h, required 1 %0d %h %h",
                     i, x, y, s, rdy, lat, q, r, LAT, eq, er);
         end
      end
   endtask

   initial begin
      test_reset();
      @(posedge clk); #1;
      test_directed();
      test_flush();
      test_back_to_back();
      test_reset_mid_op();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
